// File: rtl/dmem_pkg.sv
// Shared constants and enums for the data-memory arbiter between the MEM stage (M) and the loader (L).
package dmem_pkg;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int WORD_AW = ADDR_W - 2;

  typedef enum logic {ARB, LOCK} state_t;
  typedef enum logic [1:0] {NONE, OWN_M, OWN_L} owner_t;
endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive denied loader cycles; at_limit forces one loader grant.
module dmem_starve_ctr #(
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic dmem_clk_x70,
  input  logic dmem_rst_x70,
  input  logic inc,
  input  logic clr,
  input  logic frz,
  output logic at_limit
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge dmem_clk_x70) begin
    if (dmem_rst_x70) begin
      cnt_q <= '0;
    end else if (!frz) begin
      if (clr)
        cnt_q <= '0;
      else if (inc && (cnt_q != LIMIT))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_q == LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: MEM stage has priority, loader gets starvation-forced grants
// and exclusive locked bursts. Grants are combinational; load data returns one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = dmem_pkg::ADDR_W,
  parameter int DATA_W       = dmem_pkg::DATA_W,
  parameter int WORD_AW      = dmem_pkg::WORD_AW,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               dmem_clk_x70,
  input  logic               dmem_rst_x70,
  input  logic               m_req_x70,
  input  logic               m_we_x70,
  input  logic [ADDR_W-1:0]  m_addr_x70,
  input  logic [DATA_W-1:0]  m_wdata_x70,
  output logic               m_gnt_x70,
  output logic               m_rvalid_x70,
  output logic [DATA_W-1:0]  m_rdata_x70,
  output logic               mem_stall_x70,
  input  logic               l_req_x70,
  input  logic               l_we_x70,
  input  logic [ADDR_W-1:0]  l_addr_x70,
  input  logic [DATA_W-1:0]  l_wdata_x70,
  input  logic               l_lock_x70,
  output logic               l_gnt_x70,
  output logic               l_rvalid_x70,
  output logic [DATA_W-1:0]  l_rdata_x70,
  output logic               mem_en_x70,
  output logic               mem_we_x70,
  output logic [WORD_AW-1:0] mem_addr_x70,
  output logic [DATA_W-1:0]  mem_wdata_x70,
  input  logic [DATA_W-1:0]  mem_rdata_x70
);
  state_t state_q, state_d;
  owner_t owner_p1;
  logic   at_limit;
  logic   m_gnt, l_gnt;
  logic   [DATA_W-1:0] m_rdata_p1, l_rdata_p1;
  logic   unused_addr_lsb;

  // Byte offset is ignored: every access is a whole-word access.
  assign unused_addr_lsb = ^{m_addr_x70[1:0], l_addr_x70[1:0]};

  dmem_starve_ctr #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .dmem_clk_x70 (dmem_clk_x70),
    .dmem_rst_x70 (dmem_rst_x70),
    .inc          ((state_q == ARB) && l_req_x70 && !l_gnt),
    .clr          (l_gnt),
    .frz          (state_q == LOCK),
    .at_limit     (at_limit)
  );

  always_ff @(posedge dmem_clk_x70) begin
    if (dmem_rst_x70)
      state_q <= ARB;
    else
      state_q <= state_d;
  end

  always_comb begin
    m_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    if (!dmem_rst_x70) begin
      case (state_q)
        ARB: begin
          if (at_limit && l_req_x70)
            l_gnt = 1'b1;
          else if (m_req_x70)
            m_gnt = 1'b1;
          else if (l_req_x70)
            l_gnt = 1'b1;
          if (l_gnt && l_lock_x70)
            state_d = LOCK;
        end
        LOCK: begin
          l_gnt = l_req_x70;
          if (!l_lock_x70)
            state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign m_gnt_x70     = m_gnt;
  assign l_gnt_x70     = l_gnt;
  assign mem_stall_x70 = m_req_x70 && !m_gnt;

  always_comb begin
    mem_en_x70    = m_gnt || l_gnt;
    mem_we_x70    = 1'b0;
    mem_addr_x70  = '0;
    mem_wdata_x70 = '0;
    if (m_gnt) begin
      mem_we_x70    = m_we_x70;
      mem_addr_x70  = m_addr_x70[ADDR_W-1:2];
      mem_wdata_x70 = m_wdata_x70;
    end else if (l_gnt) begin
      mem_we_x70    = l_we_x70;
      mem_addr_x70  = l_addr_x70[ADDR_W-1:2];
      mem_wdata_x70 = l_wdata_x70;
    end
  end

  // ---- stage p1: load response owner, memory data returns this cycle ----
  always_ff @(posedge dmem_clk_x70) begin
    if (dmem_rst_x70)
      owner_p1 <= NONE;
    else if (m_gnt && !m_we_x70)
      owner_p1 <= OWN_M;
    else if (l_gnt && !l_we_x70)
      owner_p1 <= OWN_L;
    else
      owner_p1 <= NONE;
  end

  // Idle ports keep presenting their most recent load data.
  always_ff @(posedge dmem_clk_x70) begin
    if (dmem_rst_x70) begin
      m_rdata_p1 <= '0;
      l_rdata_p1 <= '0;
    end else begin
      if (owner_p1 == OWN_M)
        m_rdata_p1 <= mem_rdata_x70;
      if (owner_p1 == OWN_L)
        l_rdata_p1 <= mem_rdata_x70;
    end
  end

  assign m_rvalid_x70 = !dmem_rst_x70 && (owner_p1 == OWN_M);
  assign l_rvalid_x70 = !dmem_rst_x70 && (owner_p1 == OWN_L);
  assign m_rdata_x70  = dmem_rst_x70 ? '0 : (m_rvalid_x70 ? mem_rdata_x70 : m_rdata_p1);
  assign l_rdata_x70  = dmem_rst_x70 ? '0 : (l_rvalid_x70 ? mem_rdata_x70 : l_rdata_p1);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a single-port word memory attached to the mem_* side.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk, rst;
  logic        m_req, m_we, m_gnt, m_rvalid, mem_stall;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [7:0]  l_addr;
  logic [31:0] l_wdata, l_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        mem_clr;
  logic [31:0] mem [64];
  logic [63:0] wr;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_arbiter dut (
    .dmem_clk_x70  (clk),
    .dmem_rst_x70  (rst),
    .m_req_x70     (m_req),
    .m_we_x70      (m_we),
    .m_addr_x70    (m_addr),
    .m_wdata_x70   (m_wdata),
    .m_gnt_x70     (m_gnt),
    .m_rvalid_x70  (m_rvalid),
    .m_rdata_x70   (m_rdata),
    .mem_stall_x70 (mem_stall),
    .l_req_x70     (l_req),
    .l_we_x70      (l_we),
    .l_addr_x70    (l_addr),
    .l_wdata_x70   (l_wdata),
    .l_lock_x70    (l_lock),
    .l_gnt_x70     (l_gnt),
    .l_rvalid_x70  (l_rvalid),
    .l_rdata_x70   (l_rdata),
    .mem_en_x70    (mem_en),
    .mem_we_x70    (mem_we),
    .mem_addr_x70  (mem_addr),
    .mem_wdata_x70 (mem_wdata),
    .mem_rdata_x70 (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read back as 0xA500_0000 + word index.
  always @(posedge clk) begin
    if (mem_clr)
      wr <= '0;
    else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr]  <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= wr[mem_addr] ? mem[mem_addr] : (32'hA500_0000 | 32'(mem_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h00; m_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 8'h00; l_wdata = '0;

    // Reset state
    cyc(); #1;
    check("rst_m_gnt",   32'(m_gnt), 0);
    check("rst_stall",   32'(mem_stall), 1);
    check("rst_mem_en",  32'(mem_en), 0);
    check("rst_m_rvld",  32'(m_rvalid), 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_state",   32'(dut.state_q), 32'(ARB));
    check("rst_cnt",     32'(dut.u_starve.cnt_q), 0);
    cyc();

    // 1: M load of 0x08
    cyc(); rst = 1'b0; mem_clr = 1'b0;
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h08; #1;
    check("t1_m_gnt",    32'(m_gnt), 1);
    check("t1_mem_addr", 32'(mem_addr), 2);
    check("t1_mem_we",   32'(mem_we), 0);
    check("t1_stall",    32'(mem_stall), 0);
    cyc(); m_req = 1'b0; #1;
    check("t1_m_rvld",   32'(m_rvalid), 1);
    check("t1_m_rdata",  m_rdata, 32'hA500_0002);
    check("t1_l_rvld",   32'(l_rvalid), 0);
    cyc(); #1;
    check("t1_rvld_off", 32'(m_rvalid), 0);
    check("t1_hold",     m_rdata, 32'hA500_0002);

    // 2: contention, L forced through on cycles 5 and 10
    for (int i = 1; i <= 10; i++) begin
      cyc();
      m_req = 1'b1; m_we = 1'b0; m_addr = 8'h20;
      l_req = 1'b1; l_we = 1'b0; l_addr = 8'h24; #1;
      check($sformatf("t2_l_gnt_%0d", i), 32'(l_gnt), 32'((i == 5) || (i == 10)));
      check($sformatf("t2_m_gnt_%0d", i), 32'(m_gnt), 32'(!((i == 5) || (i == 10))));
      check($sformatf("t2_stall_%0d", i), 32'(mem_stall), 32'((i == 5) || (i == 10)));
      check($sformatf("t2_cnt_%0d", i), 32'(dut.u_starve.cnt_q), (i <= 5) ? i - 1 : i - 6);
    end
    cyc(); m_req = 1'b0; l_req = 1'b0; #1;
    check("t2_cnt_end", 32'(dut.u_starve.cnt_q), 0);

    // 3: locked L burst of 4 stores while M keeps requesting
    for (int c = 1; c <= 8; c++) begin
      cyc();
      m_req = 1'b1; m_we = 1'b0; m_addr = 8'h0C;
      l_req = 1'b1; l_we = 1'b1;
      l_addr  = (c >= 5) ? 8'((c - 5) * 4) : 8'h00;
      l_wdata = (c >= 5) ? 32'h1000 + 32'(c - 5) : 32'h1000;
      l_lock  = (c != 8);
      #1;
      check($sformatf("t3_l_gnt_%0d", c), 32'(l_gnt), 32'(c >= 5));
      check($sformatf("t3_m_gnt_%0d", c), 32'(m_gnt), 32'(c < 5));
      check($sformatf("t3_stall_%0d", c), 32'(mem_stall), 32'(c >= 5));
      if (c >= 6)
        check($sformatf("t3_lock_%0d", c), 32'(dut.state_q), 32'(LOCK));
    end
    cyc(); l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; #1;
    check("t3_state_arb", 32'(dut.state_q), 32'(ARB));
    check("t3_m_gnt_after", 32'(m_gnt), 1);
    cyc(); m_req = 1'b0; #1;
    check("t3_m_rvld",  32'(m_rvalid), 1);
    check("t3_rdata_c", m_rdata, 32'h0000_1003);

    // 4: M store then L load of the same word
    cyc(); m_req = 1'b1; m_we = 1'b1; m_addr = 8'h10; m_wdata = 32'hDEAD_BEEF; #1;
    check("t4_m_gnt",     32'(m_gnt), 1);
    check("t4_mem_we",    32'(mem_we), 1);
    check("t4_mem_addr",  32'(mem_addr), 4);
    check("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc(); m_req = 1'b0; m_we = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h10; #1;
    check("t4_l_gnt",  32'(l_gnt), 1);
    check("t4_m_rvld_st", 32'(m_rvalid), 0);
    cyc(); l_req = 1'b0; #1;
    check("t4_l_rvld",  32'(l_rvalid), 1);
    check("t4_l_rdata", l_rdata, 32'hDEAD_BEEF);
    check("t4_m_rvld",  32'(m_rvalid), 0);

    // 5: reset right after an L load grant
    cyc(); l_req = 1'b1; l_we = 1'b0; l_addr = 8'h08; #1;
    check("t5_l_gnt", 32'(l_gnt), 1);
    cyc(); l_req = 1'b0; rst = 1'b1; #1;
    check("t5_l_rvld_rst", 32'(l_rvalid), 0);
    cyc();
    check("t5_state", 32'(dut.state_q), 32'(ARB));
    check("t5_cnt",   32'(dut.u_starve.cnt_q), 0);
    rst = 1'b0; #1;
    check("t5_l_rvld", 32'(l_rvalid), 0);
    check("t5_l_rdata", l_rdata, 0);

    // 6: misaligned M load, then aligned load of the same word back to back
    cyc(); m_req = 1'b1; m_we = 1'b0; m_addr = 8'h13; #1;
    check("t6_m_gnt",    32'(m_gnt), 1);
    check("t6_mem_addr", 32'(mem_addr), 4);
    cyc(); m_addr = 8'h10; #1;
    check("t6_m_gnt2",   32'(m_gnt), 1);
    check("t6_m_rvld",   32'(m_rvalid), 1);
    check("t6_rdata_13", m_rdata, 32'hDEAD_BEEF);
    cyc(); m_req = 1'b0; #1;
    check("t6_m_rvld2",  32'(m_rvalid), 1);
    check("t6_rdata_10", m_rdata, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
